pipelined_alu_core: RTL and testbench

PIPELINED_ALU_CORE -- requirements
Module: pipelined_alu_core

---
 rtl/pipelined_alu_core_pkg.sv | 50 +++++
 rtl/pipelined_alu_unit.sv | 37 +++
 rtl/pipelined_alu_core.sv | 199 +++++++++++++++++++
 tb/tb_pipelined_alu_core.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_alu_core_pkg.sv
// ----------------------------------------------------------------------------
// pipelined_alu_core_pkg
// Shared definitions for the five-stage ALU pipeline:
//   - R-type opcode / shamt constants and the supported funct encodings
//   - alu_op_e  : ALU operation selected in decode, carried to execute
//   - decode_funct() : maps a funct field to an ALU operation plus a legal flag
// ----------------------------------------------------------------------------
package pipelined_alu_core_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [4:0] SHAMT_ZERO   = 5'd0;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } alu_op_e;

    typedef struct packed {
        logic    legal;
        alu_op_e op;
    } funct_decode_t;

    function automatic funct_decode_t decode_funct(input logic [5:0] funct);
        funct_decode_t dec;
        dec.legal = 1'b1;
        dec.op    = ALU_ADD;
        case (funct)
            FUNCT_ADD: dec.op = ALU_ADD;
            FUNCT_SUB: dec.op = ALU_SUB;
            FUNCT_AND: dec.op = ALU_AND;
            FUNCT_OR:  dec.op = ALU_OR;
            FUNCT_XOR: dec.op = ALU_XOR;
            FUNCT_SLT: dec.op = ALU_SLT;
            default:   dec.legal = 1'b0;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/pipelined_alu_unit.sv
// ----------------------------------------------------------------------------
// pipelined_alu_unit
// Purely combinational ALU used by the execute stage.
// Ports:
//   op        in   alu_op_e         operation to perform
//   operand_a in   DATA_WIDTH       first operand (rs side)
//   operand_b in   DATA_WIDTH       second operand (rt side)
//   result    out  DATA_WIDTH       ADD/SUB wrap modulo 2^DATA_WIDTH,
//                                   AND/OR/XOR bitwise, SLT signed -> 1 or 0
// ----------------------------------------------------------------------------
module pipelined_alu_unit
    import pipelined_alu_core_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_e               op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic [DATA_WIDTH-1:0] result
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case leaves it unassigned (which would infer a latch).
        result = '0;
        unique case (op)
            ALU_ADD: result = operand_a + operand_b;
            ALU_SUB: result = operand_a - operand_b;
            ALU_AND: result = operand_a & operand_b;
            ALU_OR:  result = operand_a | operand_b;
            ALU_XOR: result = operand_a ^ operand_b;
            ALU_SLT: result[0] = $signed(operand_a) < $signed(operand_b);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/pipelined_alu_core.sv
// ----------------------------------------------------------------------------
// pipelined_alu_core
// Five-stage (IF, ID, EX, MEM, WB) R-type ALU pipeline with full forwarding
// and no stalls. The register file lives outside; this core reads it
// combinationally in ID and writes it from the MEM/WB register.
// Ports:
//   clock                          in   single clock, rising edge
//   reset_n                        in   asynchronous active-low reset
//   fetch_enable                   in   instruction at PC is valid; advance fetch
//   PC                             out  32-bit fetch address
//   current_instruction            in   32-bit instruction word at PC
//   register_file_read_address_1/2 out  rs / rt of the instruction in ID
//   register_file_read_value_1/2   in   combinational register-file read data
//   register_file_write_value      out  writeback data
//   register_file_write_address    out  writeback destination
//   register_file_write_enable     out  writeback strobe (never for r0)
//   retired_count                  out  number of writebacks performed
// REG_ADDR_WIDTH is meant to be 5 or 6; the 5-bit instruction fields are
// zero-extended or truncated to it.
// ----------------------------------------------------------------------------
module pipelined_alu_core
    import pipelined_alu_core_pkg::*;
#(
    parameter int          DATA_WIDTH     = 32,
    parameter int          REG_ADDR_WIDTH = 5,
    parameter logic [31:0] PC_RESET       = 32'h0000_0000
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      fetch_enable,
    output logic [31:0]               PC,
    input  logic [31:0]               current_instruction,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_1,
    output logic [REG_ADDR_WIDTH-1:0] register_file_read_address_2,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_1,
    input  logic [DATA_WIDTH-1:0]     register_file_read_value_2,
    output logic [DATA_WIDTH-1:0]     register_file_write_value,
    output logic [REG_ADDR_WIDTH-1:0] register_file_write_address,
    output logic                      register_file_write_enable,
    output logic [31:0]               retired_count
);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0]     data_t;

    // IF/ID
    logic        if_id_valid;
    logic [31:0] if_id_instr;

    // ID/EX
    logic      id_ex_valid;
    alu_op_e   id_ex_op;
    reg_addr_t id_ex_rs, id_ex_rt, id_ex_rd;
    data_t     id_ex_value_1, id_ex_value_2;

    // EX/MEM
    logic      ex_mem_valid;
    reg_addr_t ex_mem_rd;
    data_t     ex_mem_result;

    // MEM/WB
    logic      mem_wb_valid;
    reg_addr_t mem_wb_rd;
    data_t     mem_wb_result;

    // ------------------------------------------------------------------ IF
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: clocked state is assigned with <= so every register samples the
        // pre-edge values of the others, which is what makes the stages pipeline.
        if (!reset_n) begin
            PC          <= PC_RESET;
            if_id_valid <= 1'b0;
            if_id_instr <= '0;
        end else begin
            // A disabled fetch inserts a bubble; later stages keep draining.
            if_id_valid <= fetch_enable;
            if (fetch_enable) begin
                PC          <= PC + 32'd4;
                if_id_instr <= current_instruction;
            end
        end
    end

    // ------------------------------------------------------------------ ID
    reg_addr_t     id_rs, id_rt, id_rd;
    funct_decode_t id_dec;
    logic          id_legal;
    data_t         id_value_1, id_value_2;

    assign id_rs  = reg_addr_t'(if_id_instr[25:21]);
    assign id_rt  = reg_addr_t'(if_id_instr[20:16]);
    assign id_rd  = reg_addr_t'(if_id_instr[15:11]);
    assign id_dec = decode_funct(if_id_instr[5:0]);

    assign id_legal = (if_id_instr[31:26] == OPCODE_RTYPE) &&
                      (if_id_instr[10:6]  == SHAMT_ZERO)   &&
                      id_dec.legal;

    assign register_file_read_address_1 = id_rs;
    assign register_file_read_address_2 = id_rt;

    // The register file has no internal write-through, so a value being
    // written back this cycle must be taken from the writeback port directly.
    assign id_value_1 = (register_file_write_enable && id_rs != '0 &&
                         register_file_write_address == id_rs)
                        ? register_file_write_value : register_file_read_value_1;
    assign id_value_2 = (register_file_write_enable && id_rt != '0 &&
                         register_file_write_address == id_rt)
                        ? register_file_write_value : register_file_read_value_2;

    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: data registers are reset alongside the valid bits so the
        // pipeline contents are fully deterministic coming out of reset.
        if (!reset_n) begin
            id_ex_valid   <= 1'b0;
            id_ex_op      <= ALU_ADD;
            id_ex_rs      <= '0;
            id_ex_rt      <= '0;
            id_ex_rd      <= '0;
            id_ex_value_1 <= '0;
            id_ex_value_2 <= '0;
        end else begin
            id_ex_valid   <= if_id_valid && id_legal;
            id_ex_op      <= id_dec.op;
            id_ex_rs      <= id_rs;
            id_ex_rt      <= id_rt;
            id_ex_rd      <= id_rd;
            id_ex_value_1 <= id_value_1;
            id_ex_value_2 <= id_value_2;
        end
    end

    // ------------------------------------------------------------------ EX
    data_t ex_operand_a, ex_operand_b, ex_result;

    // The younger producer (EX/MEM) is checked first so it wins over MEM/WB.
    always_comb begin
        ex_operand_a = id_ex_value_1;
        if (ex_mem_valid && id_ex_rs != '0 && ex_mem_rd == id_ex_rs)
            ex_operand_a = ex_mem_result;
        else if (mem_wb_valid && id_ex_rs != '0 && mem_wb_rd == id_ex_rs)
            ex_operand_a = mem_wb_result;

        ex_operand_b = id_ex_value_2;
        if (ex_mem_valid && id_ex_rt != '0 && ex_mem_rd == id_ex_rt)
            ex_operand_b = ex_mem_result;
        else if (mem_wb_valid && id_ex_rt != '0 && mem_wb_rd == id_ex_rt)
            ex_operand_b = mem_wb_result;
    end

    pipelined_alu_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_alu (
        .op        (id_ex_op),
        .operand_a (ex_operand_a),
        .operand_b (ex_operand_b),
        .result    (ex_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_mem_valid  <= 1'b0;
            ex_mem_rd     <= '0;
            ex_mem_result <= '0;
        end else begin
            ex_mem_valid  <= id_ex_valid;
            ex_mem_rd     <= id_ex_rd;
            ex_mem_result <= ex_result;
        end
    end

    // ----------------------------------------------------------- MEM / WB
    // No memory operations exist; MEM simply carries the result one stage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_wb_valid  <= 1'b0;
            mem_wb_rd     <= '0;
            mem_wb_result <= '0;
        end else begin
            mem_wb_valid  <= ex_mem_valid;
            mem_wb_rd     <= ex_mem_rd;
            mem_wb_result <= ex_mem_result;
        end
    end

    // Writes to r0 are discarded here rather than in decode, so they still
    // flow through the pipeline but never reach the register file.
    assign register_file_write_enable  = mem_wb_valid && (mem_wb_rd != '0);
    assign register_file_write_address = mem_wb_rd;
    assign register_file_write_value   = mem_wb_result;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            retired_count <= '0;
        else if (register_file_write_enable)
            retired_count <= retired_count + 32'd1;
    end

endmodule

// File: tb/tb_pipelined_alu_core.sv
// ----------------------------------------------------------------------------
// tb_pipelined_alu_core
// Directed bench for pipelined_alu_core. A small register-file model supplies
// read data and absorbs writebacks; every expected writeback, PC and count is
// a hand-computed constant in the step sequence below.
// ----------------------------------------------------------------------------
module tb_pipelined_alu_core;

    localparam logic [31:0] PC_RST = 32'hFFFF_FFF0;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [31:0] NOP  = 32'h0000_0000;

    logic        clock;
    logic        reset_n;
    logic        fetch_enable;
    logic [31:0] pc;
    logic [31:0] current_instruction;
    logic [4:0]  register_file_read_address_1;
    logic [4:0]  register_file_read_address_2;
    logic [31:0] register_file_read_value_1;
    logic [31:0] register_file_read_value_2;
    logic [31:0] register_file_write_value;
    logic [4:0]  register_file_write_address;
    logic        register_file_write_enable;
    logic [31:0] retired_count;

    int tests_run    = 0;
    int tests_failed = 0;

    pipelined_alu_core #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .PC_RESET       (PC_RST)
    ) dut (
        .clock                        (clock),
        .reset_n                      (reset_n),
        .fetch_enable                 (fetch_enable),
        .PC                           (pc),
        .current_instruction          (current_instruction),
        .register_file_read_address_1 (register_file_read_address_1),
        .register_file_read_address_2 (register_file_read_address_2),
        .register_file_read_value_1   (register_file_read_value_1),
        .register_file_read_value_2   (register_file_read_value_2),
        .register_file_write_value    (register_file_write_value),
        .register_file_write_address  (register_file_write_address),
        .register_file_write_enable   (register_file_write_enable),
        .retired_count                (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Register-file model: seeded on reset, written by the writeback port.
    logic [31:0] regs [32];
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
            regs[1]  <= 32'd5;
            regs[2]  <= 32'd7;
            regs[20] <= 32'hFFFF_FFFF;
            regs[21] <= 32'd1;
        end else if (register_file_write_enable) begin
            regs[register_file_write_address] <= register_file_write_value;
        end
    end
    assign register_file_read_value_1 = regs[register_file_read_address_1];
    assign register_file_read_value_2 = regs[register_file_read_address_2];

    function automatic logic [31:0] rtype(input logic [5:0] funct, input logic [4:0] rd,
                                          input logic [4:0] rs, input logic [4:0] rt);
        return {6'd0, rs, rt, rd, 5'd0, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of input, then check writeback outputs at the falling edge.
    task automatic step(input string tag, input logic en, input logic [31:0] instr,
                        input logic exp_we, input logic [4:0] exp_addr,
                        input logic [31:0] exp_val);
        fetch_enable        = en;
        current_instruction = instr;
        @(posedge clock);
        @(negedge clock);
        check({tag, ".we"}, 32'(register_file_write_enable), 32'(exp_we));
        if (exp_we) begin
            check({tag, ".addr"}, 32'(register_file_write_address), 32'(exp_addr));
            check({tag, ".value"}, register_file_write_value, exp_val);
        end
    endtask

    task automatic idle(input string tag, input logic en, input logic [31:0] instr);
        step(tag, en, instr, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic wb(input string tag, input logic en, input logic [31:0] instr,
                      input logic [4:0] addr, input logic [31:0] val);
        step(tag, en, instr, 1'b1, addr, val);
    endtask

    initial begin
        reset_n             = 1'b0;
        fetch_enable        = 1'b0;
        current_instruction = NOP;
        repeat (2) @(negedge clock);
        check("rst.pc", pc, PC_RST);
        check("rst.we", 32'(register_file_write_enable), 32'd0);
        check("rst.count", retired_count, 32'd0);
        reset_n = 1'b1;

        // Single ADD r3 = r1 + r2 : write four edges after capture.
        idle("a1", 1'b1, rtype(F_ADD, 5'd3, 5'd1, 5'd2));
        check("a1.pc", pc, 32'hFFFF_FFF4);
        check("a1.rs", 32'(register_file_read_address_1), 32'd1);
        check("a1.rt", 32'(register_file_read_address_2), 32'd2);
        idle("a2", 1'b0, NOP);
        idle("a3", 1'b0, NOP);
        check("a3.pc", pc, 32'hFFFF_FFF4);
        wb  ("a4", 1'b0, NOP, 5'd3, 32'd12);
        check("a4.count", retired_count, 32'd0);
        idle("a5", 1'b0, NOP);
        check("a5.count", retired_count, 32'd1);

        // Back-to-back dependency via EX/MEM: r6 = 12, r7 = r6 - r1 = 7.
        idle("b1", 1'b1, rtype(F_ADD, 5'd6, 5'd1, 5'd2));
        idle("b2", 1'b1, rtype(F_SUB, 5'd7, 5'd6, 5'd1));
        check("b2.pc", pc, 32'hFFFF_FFFC);
        idle("b3", 1'b0, NOP);
        wb  ("b4", 1'b0, NOP, 5'd6, 32'd12);
        wb  ("b5", 1'b0, NOP, 5'd7, 32'd7);
        idle("b6", 1'b0, NOP);
        check("b6.count", retired_count, 32'd3);

        // MEM/WB forwarding, dependency chain with ID bypass, EX/MEM priority.
        idle("s1",  1'b1, rtype(F_ADD, 5'd8,  5'd1,  5'd2));   // r8  = 12
        check("s1.pc_wrap", pc, 32'h0000_0000);
        idle("s2",  1'b0, NOP);
        idle("s3",  1'b1, rtype(F_AND, 5'd9,  5'd8,  5'd8));   // r9  = 12
        wb  ("s4",  1'b1, rtype(F_ADD, 5'd10, 5'd1,  5'd1), 5'd8, 32'd12);  // r10 = 10
        idle("s5",  1'b1, rtype(F_ADD, 5'd11, 5'd10, 5'd2));   // r11 = 17
        wb  ("s6",  1'b1, rtype(F_ADD, 5'd12, 5'd11, 5'd10), 5'd9, 32'd12); // r12 = 27
        wb  ("s7",  1'b1, rtype(F_SUB, 5'd13, 5'd12, 5'd10), 5'd10, 32'd10); // r13 = 17
        wb  ("s8",  1'b1, rtype(F_ADD, 5'd14, 5'd1,  5'd1), 5'd11, 32'd17); // r14 = 10
        wb  ("s9",  1'b1, rtype(F_ADD, 5'd14, 5'd2,  5'd2), 5'd12, 32'd27); // r14 = 14
        wb  ("s10", 1'b1, rtype(F_OR,  5'd15, 5'd14, 5'd0), 5'd13, 32'd17); // r15 = 14
        wb  ("s11", 1'b0, NOP, 5'd14, 32'd10);
        wb  ("s12", 1'b0, NOP, 5'd14, 32'd14);
        wb  ("s13", 1'b0, NOP, 5'd15, 32'd14);
        idle("s14", 1'b0, NOP);
        check("s14.count", retired_count, 32'd12);

        // Signed SLT both ways, ADD wrap to 0, write to r0 suppressed.
        idle("d1", 1'b1, rtype(F_SLT, 5'd22, 5'd20, 5'd21));
        idle("d2", 1'b1, rtype(F_SLT, 5'd24, 5'd21, 5'd20));
        idle("d3", 1'b1, rtype(F_ADD, 5'd23, 5'd20, 5'd21));
        wb  ("d4", 1'b1, rtype(F_ADD, 5'd0,  5'd1,  5'd2), 5'd22, 32'd1);
        check("d4.pc", pc, 32'h0000_0030);
        wb  ("d5", 1'b0, NOP, 5'd24, 32'd0);
        wb  ("d6", 1'b0, NOP, 5'd23, 32'd0);
        idle("d7", 1'b0, NOP);
        check("d7.count", retired_count, 32'd15);
        idle("d8", 1'b0, NOP);
        check("d8.count", retired_count, 32'd15);

        // Fetch stalled three cycles, then illegal funct and nonzero shamt.
        idle("e1", 1'b1, rtype(F_ADD, 5'd25, 5'd1, 5'd2));
        idle("e2", 1'b0, NOP);
        idle("e3", 1'b0, NOP);
        wb  ("e4", 1'b0, NOP, 5'd25, 32'd12);
        check("e4.pc_hold", pc, 32'h0000_0034);
        idle("e5", 1'b1, rtype(F_XOR, 5'd26, 5'd1, 5'd2));
        idle("e6", 1'b1, rtype(6'h21, 5'd27, 5'd1, 5'd2));
        idle("e7", 1'b1, rtype(F_OR,  5'd28, 5'd1, 5'd2));
        wb  ("e8", 1'b1, rtype(F_ADD, 5'd29, 5'd1, 5'd2) | 32'h0000_0040, 5'd26, 32'd2);
        check("e8.pc", pc, 32'h0000_0044);
        idle("e9", 1'b0, NOP);
        wb  ("e10", 1'b0, NOP, 5'd28, 32'd7);
        idle("e11", 1'b0, NOP);
        check("e11.count", retired_count, 32'd18);

        // Reset with three instructions in flight.
        idle("f1", 1'b1, rtype(F_ADD, 5'd30, 5'd1, 5'd2));
        idle("f2", 1'b1, rtype(F_ADD, 5'd31, 5'd1, 5'd2));
        idle("f3", 1'b1, rtype(F_SUB, 5'd3,  5'd2, 5'd1));
        reset_n = 1'b0;
        #1;
        check("f.rst_pc", pc, PC_RST);
        check("f.rst_we", 32'(register_file_write_enable), 32'd0);
        check("f.rst_count", retired_count, 32'd0);
        repeat (2) begin
            @(posedge clock);
            @(negedge clock);
            check("f.rst_hold_pc", pc, PC_RST);
            check("f.rst_hold_we", 32'(register_file_write_enable), 32'd0);
        end
        reset_n = 1'b1;
        idle("g1", 1'b0, NOP);
        idle("g2", 1'b0, NOP);
        idle("g3", 1'b0, NOP);
        idle("g4", 1'b0, NOP);
        check("g4.count", retired_count, 32'd0);
        idle("g5", 1'b1, rtype(F_ADD, 5'd3, 5'd1, 5'd2));
        check("g5.pc", pc, 32'hFFFF_FFF4);
        idle("g6", 1'b0, NOP);
        idle("g7", 1'b0, NOP);
        wb  ("g8", 1'b0, NOP, 5'd3, 32'd12);
        idle("g9", 1'b0, NOP);
        check("g9.count", retired_count, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
